glitch_filter_nch: RTL

Parametrised N-channel digital deglitch filter for slow serial lines (I2C SCL/SDA and similar open-drain inputs). Each channel propagates an input level change only after the input has been sampled at the new level on a runtime-programmable number of consecutive clock edges. It also reports rise/fall edge pulses and rejected glitches. It sits between the pad synchronisers and the protocol FSMs.

---
 rtl/glitch_filter_pkg.sv | 5 +
 rtl/glitch_filter_nch_if.sv | 17 +
 rtl/glitch_filter_ch.sv | 82 ++++++++
 rtl/glitch_filter_nch.sv | 29 ++
 4 files changed

// File: rtl/glitch_filter_pkg.sv
// glitch_filter_pkg: shared FSM state type and default counter width for the glitch filter
package glitch_filter_pkg;
    typedef enum logic [0:0] {IDLE, COUNT} state_t;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/glitch_filter_nch_if.sv
// glitch_filter_nch_if: control, raw line and filtered/event signals of the N-channel glitch filter
interface glitch_filter_nch_if
    import glitch_filter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              en;
    logic [CNT_W-1:0]  thresh;
    logic [NUM_CH-1:0] in;
    logic [NUM_CH-1:0] out;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] glitch;
    modport master (output en, thresh, in, input out, rise, fall, glitch);
    modport slave  (input en, thresh, in, output out, rise, fall, glitch);
endinterface

// File: rtl/glitch_filter_ch.sv
// glitch_filter_ch: one deglitch channel accepting a new level after thresh consecutive matching samples
module glitch_filter_ch
    import glitch_filter_pkg::*;
#(
    parameter int   CNT_W   = CNT_W_DEF,
    parameter logic RST_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic             in_i,
    output logic             out_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             glitch_o
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             cand_q, cand_d, out_q, out_d;
    logic             rise_q, rise_d, fall_q, fall_d, glitch_q, glitch_d;
    logic             commit;
    always_comb begin
        cnt_inc  = {1'b0, cnt_q} + 1'b1;
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = '0;
        out_d    = out_q;
        glitch_d = 1'b0;
        commit   = 1'b0;
        if (en_i) begin
            if (state_q == IDLE) begin
                if (in_i != out_q) begin
                    if (thresh_i <= CNT_W'(1)) commit = 1'b1;
                    else begin
                        cand_d  = in_i;
                        cnt_d   = CNT_W'(1);
                        state_d = COUNT;
                    end
                end
            end else if (in_i != cand_q) begin
                glitch_d = 1'b1;
                state_d  = IDLE;
            end else if (cnt_inc >= {1'b0, thresh_i}) begin
                commit  = 1'b1;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
            end
        end else begin
            state_d = IDLE;
        end
        // in_i equals cand_q whenever a COUNT commits, so in_i is the new level in both paths
        if (commit) out_d = in_i;
        rise_d = commit && in_i;
        fall_d = commit && !in_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= 1'b0;
            out_q    <= RST_BIT;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end
    assign out_o    = out_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign glitch_o = glitch_q;
endmodule

// File: rtl/glitch_filter_nch.sv
// glitch_filter_nch: NUM_CH independent deglitch channels sharing enable and threshold
module glitch_filter_nch
    import glitch_filter_pkg::*;
#(
    parameter int                NUM_CH  = 2,
    parameter int                CNT_W   = CNT_W_DEF,
    parameter logic [NUM_CH-1:0] RST_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    glitch_filter_nch_if.slave bus
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        glitch_filter_ch #(
            .CNT_W   (CNT_W),
            .RST_BIT (RST_VAL[i])
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en_i     (bus.en),
            .thresh_i (bus.thresh),
            .in_i     (bus.in[i]),
            .out_o    (bus.out[i]),
            .rise_o   (bus.rise[i]),
            .fall_o   (bus.fall[i]),
            .glitch_o (bus.glitch[i])
        );
    end
endmodule
